pwm_multi_gen: RTL
==================

Name: pwm_multi_gen

Overview:
Parametrised multi-channel PWM generator for board-level dimming and motor drive. It is the successor to the single-channel 4-bit switch-driven PWM generator. All channels share one prescaler and one period counter. It adds programmable period, edge- or centre-aligned counting, and double-buffered (shadow) duty/period registers that update glitch-free at the period boundary.

Parameters:
NCH, 4, number of PWM channels
RES, 8, counter/duty/period width in bits
PRESC_W, 16, prescaler compare width

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  synchronous, active-high reset
en  input  1  run enable; low = counters cleared, outputs low
prescale  input  PRESC_W  count tick every prescale+1 clk cycles
period  input  RES  counter top value (shadowed)
center_mode  input  1  0 = edge-aligned, 1 = centre-aligned (shadowed)
duty  input  NCH*RES  channel i duty at bits [i*RES +: RES] (shadowed)
duty_load  input  1  one-cycle strobe: capture period/center_mode/duty into shadow
pwm_out  output  NCH  registered PWM outputs
period_tick  output  1  one-cycle pulse at each period boundary
load_pending  output  1  shadow holds values not yet applied

Behaviour:
- Reset (rst=1 at posedge): prescaler count, main counter, shadow regs and active regs go to 0; direction = up; pwm_out=0, period_tick=0, load_pending=0.
- Prescaler: presc_cnt counts 0..prescale, and tick=1 when presc_cnt==prescale. prescale=0 gives tick every cycle. prescale is used live (not shadowed). Counting runs only while en=1.
- Edge mode: on tick, cnt goes 0,1,..,period_act and then back to 0. Period = period_act+1 ticks.
- Centre mode: on tick, cnt counts up to period_act, then down to 0, then up again. Direction flips when cnt reaches period_act (going up) or 0 (going down). Period = 2*period_act ticks.
- period_act=0 (either mode): cnt stays 0, and every tick is a boundary.
- Boundary event: the tick on which cnt moves to 0 (edge: cnt==period_act; centre: dir=down and cnt==1; or period_act==0).
- Boundary actions: period_tick pulses high in the next cycle, coincident with cnt=0. If load_pending=1, active regs take the shadow values and load_pending clears, effective for the new period.
- duty_load: shadow is written with the current inputs, and load_pending=1 in the next cycle.
- duty_load on the same cycle as a boundary: the incoming values are applied directly to the active regs, and load_pending stays 0.
- Repeated duty_load before a boundary: last write wins.
- Compare: pwm_out[i] registered as (cnt < duty_act[i]), so pwm_out lags cnt by one clk.
  - duty 0 gives constant low.
  - Edge mode, duty > period_act: constant high.
  - Centre mode, duty > period_act: constant high.
- Centre-mode output is symmetric about cnt=period_act.
- en=0:
  - presc_cnt=0, cnt=0, dir=up; pwm_out=0 next cycle; period_tick=0.
  - Shadow loads still accepted. Pending shadow is applied immediately to the active regs and load_pending clears.
  - Rising en starts from cnt=0 with a full first period.
- Mid-period changes of inputs without duty_load have no effect, except prescale.
- Arithmetic: all compares are unsigned RES bits. Centre period 2*period_act needs no extra width, because direction is tracked with a 1-bit flag.
- rst mid-operation has priority over en and duty_load. Outputs are low the cycle after the reset edge.

Decomposition:
- pwm_pkg:
  - enum count_mode_t {EDGE, CENTER}
  - a helper function slicing channel duty from the packed bus
- Sub-module pwm_prescaler (PRESC_W, ports clk, rst, en, prescale, tick). The top holds the counter/direction, shadow/active regs and a generate loop of NCH comparators.

Test Plan:
1. Edge duty/off-at-zero (NCH=4, RES=4, prescale=0, en=1): load period=9, duty={0,3,9,12}. Response: over each 10-cycle period ch0=0 high cycles, ch1=3, ch2=9, ch3=10 (constant high); period_tick every 10 clks.
2. Centre mode (period=4, duty ch0=2, prescale=0): cnt sequence 0,1,2,3,4,3,2,1. Response: ch0 high 3 of 8 cycles, symmetric; period_tick every 8 clks.
3. Prescaler (prescale=2, edge, period=3, duty ch0=2): each count lasts 3 clks. Response: ch0 high 6 of 12 clks; period_tick every 12 clks.
4. Shadow timing: mid-period duty_load of ch0 duty 3→7. Response: current period still 3 high; load_pending=1 until boundary; next period 7 high. A load on the boundary cycle applies immediately with load_pending=0.
5. en/rst mid-period: drop en at cnt=5. Response: pwm_out=0 next clk; pending load applied. Re-enable restarts at cnt=0 with a full period. rst asserted with en=1: all outputs 0 next clk, and duty_act=0 until a new load.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM generator.
package pwm_pkg;

  typedef enum logic {
    EDGE   = 1'b0,
    CENTER = 1'b1
  } count_mode_t;

  localparam int MAX_BUS_W = 1024;
  localparam int MAX_RES_W = 32;

  // Extract channel ch (res bits wide) from a packed duty bus, zero-extended.
  function automatic logic [MAX_RES_W-1:0] duty_slice(
    input logic [MAX_BUS_W-1:0] bus,
    input int                   ch,
    input int                   res
  );
    logic [MAX_BUS_W-1:0] shifted;
    logic [MAX_RES_W-1:0] mask;
    shifted = bus >> (ch * res);
    mask    = (res >= MAX_RES_W) ? '1 : ((MAX_RES_W'(1) << res) - MAX_RES_W'(1));
    return shifted[MAX_RES_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Shared clock-enable divider: tick once every prescale+1 cycles while enabled.
module pwm_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] prescale,
  output logic               tick
);

  logic [PRESC_W-1:0] r_presc_cnt;
  logic               w_wrap;

  // prescale is live, so a lowered value must still wrap an already-higher count
  assign w_wrap = (r_presc_cnt >= prescale);
  assign tick   = en && w_wrap;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_presc_cnt <= '0;
    end else if (w_wrap) begin
      r_presc_cnt <= '0;
    end else begin
      r_presc_cnt <= r_presc_cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: shared prescaler and period counter, edge or
// centre-aligned counting, shadowed period/mode/duty applied at period boundaries.
module pwm_multi_gen
  import pwm_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int RES     = 8,
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [RES-1:0]     period,
  input  logic               center_mode,
  input  logic [NCH*RES-1:0] duty,
  input  logic               duty_load,
  output logic [NCH-1:0]     pwm_out,
  output logic               period_tick,
  output logic               load_pending
);

  logic               w_tick;
  logic               w_boundary;
  logic [RES-1:0]     w_cnt_inc;
  logic [NCH-1:0]     w_cmp;

  logic [RES-1:0]     r_cnt;
  logic               r_dir_down;

  logic [RES-1:0]     r_period_sh;
  logic [RES-1:0]     r_period_act;
  count_mode_t        r_mode_sh;
  count_mode_t        r_mode_act;
  logic [NCH*RES-1:0] r_duty_sh;
  logic [NCH*RES-1:0] r_duty_act;
  logic               r_pending;

  logic [NCH-1:0]     r_pwm;
  logic               r_period_tick;

  pwm_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .prescale (prescale),
    .tick     (w_tick)
  );

  assign w_cnt_inc = r_cnt + RES'(1);

  // A boundary is the tick on which the counter returns to 0.
  always_comb begin
    w_boundary = 1'b0;
    if (w_tick) begin
      if (r_period_act == '0) begin
        w_boundary = 1'b1;
      end else if (r_mode_act == EDGE) begin
        w_boundary = (r_cnt >= r_period_act);
      end else begin
        w_boundary = r_dir_down && (r_cnt == RES'(1));
      end
    end
  end

  // ---- stage 0: period counter and direction ----
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_cnt      <= '0;
      r_dir_down <= 1'b0;
    end else if (w_tick) begin
      if (w_boundary) begin
        r_cnt      <= '0;
        r_dir_down <= 1'b0;
      end else if (r_mode_act == EDGE) begin
        r_cnt <= w_cnt_inc;
      end else if (!r_dir_down) begin
        r_cnt <= w_cnt_inc;
        if (w_cnt_inc >= r_period_act) begin
          r_dir_down <= 1'b1;
        end
      end else begin
        r_cnt <= r_cnt - RES'(1);
      end
    end
  end

  // ---- shadow / active register bank ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_period_sh  <= '0;
      r_period_act <= '0;
      r_mode_sh    <= EDGE;
      r_mode_act   <= EDGE;
      r_duty_sh    <= '0;
      r_duty_act   <= '0;
      r_pending    <= 1'b0;
    end else begin
      if (duty_load) begin
        r_period_sh <= period;
        r_mode_sh   <= count_mode_t'(center_mode);
        r_duty_sh   <= duty;
      end
      // While stopped there is no period to protect, so loads go straight through.
      if (!en || w_boundary) begin
        if (duty_load) begin
          r_period_act <= period;
          r_mode_act   <= count_mode_t'(center_mode);
          r_duty_act   <= duty;
        end else if (r_pending) begin
          r_period_act <= r_period_sh;
          r_mode_act   <= r_mode_sh;
          r_duty_act   <= r_duty_sh;
        end
        r_pending <= 1'b0;
      end else if (duty_load) begin
        r_pending <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [RES-1:0] w_duty_ch;
    assign w_duty_ch = RES'(duty_slice(MAX_BUS_W'(r_duty_act), g, RES));
    assign w_cmp[g]  = (r_cnt < w_duty_ch);
  end

  // ---- stage 1: registered outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm         <= '0;
      r_period_tick <= 1'b0;
    end else begin
      r_pwm         <= en ? w_cmp : '0;
      r_period_tick <= w_boundary;
    end
  end

  assign pwm_out      = r_pwm;
  assign period_tick  = r_period_tick;
  assign load_pending = r_pending;

endmodule
